// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: state codes, opcodes,
// ALU op and mux-select codes, plus the decoded instruction-class bundle.
package cpu_ctrl_pkg;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_EX_R     = 4'd3;
    localparam logic [3:0] S_EX_I     = 4'd4;
    localparam logic [3:0] S_EX_ADDR  = 4'd5;
    localparam logic [3:0] S_MEM_RD   = 4'd6;
    localparam logic [3:0] S_MEM_WR   = 4'd7;
    localparam logic [3:0] S_EX_BR    = 4'd8;
    localparam logic [3:0] S_EX_JAL   = 4'd9;
    localparam logic [3:0] S_EX_JALR  = 4'd10;
    localparam logic [3:0] S_EX_LUI   = 4'd11;
    localparam logic [3:0] S_EX_AUIPC = 4'd12;
    localparam logic [3:0] S_WB_ALU   = 4'd13;
    localparam logic [3:0] S_WB_MEM   = 4'd14;
    localparam logic [3:0] S_TRAP     = 4'd15;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_ITYPE = 2'b11;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;
    localparam logic [1:0] SRC_A_ZERO  = 2'b11;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    typedef struct packed {
        logic r;
        logic i;
        logic load;
        logic store;
        logic branch;
        logic jal;
        logic jalr;
        logic lui;
        logic auipc;
    } op_class_t;

    function automatic logic is_mem_state(input logic [3:0] s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle. illegal_instr exists only
// when MULTICYCLE_CTRL_TRAP_EN is defined.
interface multicycle_ctrl_if;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       branch_taken;
    logic [1:0] alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_write;
    logic       pc_src;
    logic       ir_write;
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       instr_done;
`ifdef MULTICYCLE_CTRL_TRAP_EN
    logic       illegal_instr;
`endif

    modport master (
`ifdef MULTICYCLE_CTRL_TRAP_EN
        output illegal_instr,
`endif
        input  opcode, mem_ready, branch_taken,
        output alu_op, alu_src_a, alu_src_b, pc_write, pc_src, ir_write,
        output mem_req, mem_we, i_or_d, reg_write, wb_sel, instr_done
    );

    modport slave (
`ifdef MULTICYCLE_CTRL_TRAP_EN
        input  illegal_instr,
`endif
        output opcode, mem_ready, branch_taken,
        input  alu_op, alu_src_a, alu_src_b, pc_write, pc_src, ir_write,
        input  mem_req, mem_we, i_or_d, reg_write, wb_sel, instr_done
    );
endinterface

// File: rtl/multicycle_opdec.sv
// Combinational opcode classifier: one-hot instruction class plus legal bit.
// Zero latency; no handshake.
module multicycle_opdec
    import cpu_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  cls,
    output logic       legal
);
    always_comb begin
        cls = '0;
        case (opcode)
            OPC_R:      cls.r      = 1'b1;
            OPC_I:      cls.i      = 1'b1;
            OPC_LOAD:   cls.load   = 1'b1;
            OPC_STORE:  cls.store  = 1'b1;
            OPC_BRANCH: cls.branch = 1'b1;
            OPC_JAL:    cls.jal    = 1'b1;
            OPC_JALR:   cls.jalr   = 1'b1;
            OPC_LUI:    cls.lui    = 1'b1;
            OPC_AUIPC:  cls.auipc  = 1'b1;
            default:    cls        = '0;
        endcase
        legal = |cls;
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM; Moore outputs except the mem_ready/branch_taken
// qualified enables. Memory states hold until mem_ready (or watchdog timeout).
// Optional trap state compiled in with MULTICYCLE_CTRL_TRAP_EN.
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    multicycle_ctrl_if.master  bus
);
`ifdef MULTICYCLE_CTRL_TRAP_EN
    localparam logic [3:0] S_TIMEOUT = S_TRAP;
`else
    localparam logic [3:0] S_TIMEOUT = S_FETCH;
`endif

    logic [3:0] state, state_nxt;
    op_class_t  cls;
    logic       legal;
    logic       wd_hit;

    multicycle_opdec u_opdec (
        .opcode (bus.opcode),
        .cls    (cls),
        .legal  (legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    generate
        if (WAIT_MAX > 0) begin : g_wdog
            localparam int CW = $clog2(WAIT_MAX + 1);
            logic [CW-1:0] wait_cnt;

            // Cleared on any state change so each memory state starts a fresh budget.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    wait_cnt <= '0;
                else if ((state_nxt != state) || wd_hit)
                    wait_cnt <= '0;
                else if (is_mem_state(state))
                    wait_cnt <= wait_cnt + CW'(1);
            end

            assign wd_hit = is_mem_state(state) && !bus.mem_ready &&
                            (wait_cnt == CW'(WAIT_MAX));
        end else begin : g_no_wdog
            assign wd_hit = 1'b0;
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: state_nxt = S_FETCH;
            S_FETCH: begin
                if (bus.mem_ready) state_nxt = S_DECODE;
                else if (wd_hit)   state_nxt = S_TIMEOUT;
            end
            S_DECODE: begin
                if (cls.r)                        state_nxt = S_EX_R;
                else if (cls.i)                   state_nxt = S_EX_I;
                else if (cls.load || cls.store)   state_nxt = S_EX_ADDR;
                else if (cls.branch)              state_nxt = S_EX_BR;
                else if (cls.jal)                 state_nxt = S_EX_JAL;
                else if (cls.jalr)                state_nxt = S_EX_JALR;
                else if (cls.lui)                 state_nxt = S_EX_LUI;
                else if (cls.auipc)               state_nxt = S_EX_AUIPC;
`ifdef MULTICYCLE_CTRL_TRAP_EN
                else                              state_nxt = S_TRAP;
`else
                else                              state_nxt = S_FETCH;
`endif
            end
            S_EX_R, S_EX_I, S_EX_LUI, S_EX_AUIPC: state_nxt = S_WB_ALU;
            S_EX_ADDR: state_nxt = cls.load ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (bus.mem_ready) state_nxt = S_WB_MEM;
                else if (wd_hit)   state_nxt = S_TIMEOUT;
            end
            S_MEM_WR: begin
                if (bus.mem_ready) state_nxt = S_FETCH;
                else if (wd_hit)   state_nxt = S_TIMEOUT;
            end
            S_EX_BR, S_EX_JAL, S_EX_JALR, S_WB_ALU, S_WB_MEM: state_nxt = S_FETCH;
`ifdef MULTICYCLE_CTRL_TRAP_EN
            S_TRAP: state_nxt = S_TRAP;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    logic [1:0] alu_op, alu_src_a, alu_src_b, wb_sel;
    logic       pc_write, pc_src, ir_write, mem_req, mem_we, i_or_d;
    logic       reg_write, instr_done, illegal;

    always_comb begin
        alu_op     = ALU_ADD;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        wb_sel     = WB_ALUOUT;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        i_or_d     = 1'b0;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRC_B_FOUR;
                ir_write  = bus.mem_ready;
                pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
                alu_src_a  = SRC_A_OLDPC;
                alu_src_b  = SRC_B_IMM;
`ifndef MULTICYCLE_CTRL_TRAP_EN
                instr_done = !legal;
`endif
            end
            S_EX_R: begin
                alu_src_a = SRC_A_RS1;
                alu_op    = ALU_RTYPE;
            end
            S_EX_I: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                alu_op    = ALU_ITYPE;
            end
            S_EX_LUI: begin
                alu_src_a = SRC_A_ZERO;
                alu_src_b = SRC_B_IMM;
            end
            S_EX_AUIPC: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
            end
            S_EX_ADDR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
            end
            S_MEM_WR: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                i_or_d     = 1'b1;
                instr_done = bus.mem_ready;
            end
            S_EX_BR: begin
                alu_src_a  = SRC_A_RS1;
                alu_op     = ALU_SUB;
                pc_write   = bus.branch_taken;
                pc_src     = 1'b1;
                instr_done = 1'b1;
            end
            S_EX_JAL: begin
                // Target was formed in decode (oldPC + imm) and sits in ALUOut.
                pc_write   = 1'b1;
                pc_src     = 1'b1;
                reg_write  = 1'b1;
                wb_sel     = WB_PC;
                instr_done = 1'b1;
            end
            S_EX_JALR: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                wb_sel     = WB_PC;
                instr_done = 1'b1;
            end
            S_WB_ALU: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                wb_sel     = WB_MDR;
                instr_done = 1'b1;
            end
`ifdef MULTICYCLE_CTRL_TRAP_EN
            S_TRAP: illegal = 1'b1;
`endif
            default: illegal = 1'b0;
        endcase
    end

    assign bus.alu_op     = alu_op;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.pc_write   = pc_write;
    assign bus.pc_src     = pc_src;
    assign bus.ir_write   = ir_write;
    assign bus.mem_req    = mem_req;
    assign bus.mem_we     = mem_we;
    assign bus.i_or_d     = i_or_d;
    assign bus.reg_write  = reg_write;
    assign bus.wb_sel     = wb_sel;
    assign bus.instr_done = instr_done;
`ifdef MULTICYCLE_CTRL_TRAP_EN
    assign bus.illegal_instr = illegal;
`else
    logic unused_illegal;
    assign unused_illegal = illegal;
`endif

endmodule
